// File: rtl/input_debouncer_pkg.sv
// rtl/input_debouncer_pkg.sv - shared state encoding and default sizing for the input debouncer
package input_debouncer_pkg;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    STABLE_LO,
    CHECK_HI,
    STABLE_HI,
    CHECK_LO
  } state_t;

endpackage

// File: rtl/input_debouncer_sync_chain.sv
// rtl/input_debouncer_sync_chain.sv - reset-to-zero flop chain bringing the raw input into clk_i
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchronise and debounce a bouncy input; edge pulses only when
// INPUT_DEBOUNCER_EDGE_EN is defined, otherwise rise_o/fall_o are tied low
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             level;
  logic             go_hi;
  logic             go_lo;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (raw_i),
    .q_o     (s)
  );

  // A single-cycle debounce skips the CHECK states and accepts straight from STABLE.
  always_comb begin
    go_hi = 1'b0;
    go_lo = 1'b0;
    if (DEBOUNCE_CYCLES == 1) begin
      go_hi = (state == STABLE_LO) && s;
      go_lo = (state == STABLE_HI) && !s;
    end else begin
      go_hi = (state == CHECK_HI) && s && (cnt == CNT_LAST);
      go_lo = (state == CHECK_LO) && !s && (cnt == CNT_LAST);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= STABLE_LO;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      case (state)
        STABLE_LO: begin
          if (go_hi) begin
            state <= STABLE_HI;
            level <= 1'b1;
          end else if (s) begin
            state <= CHECK_HI;
            cnt   <= CNT_ONE;
          end
        end
        CHECK_HI: begin
          if (go_hi) begin
            state <= STABLE_HI;
            cnt   <= '0;
            level <= 1'b1;
          end else if (s) begin
            cnt <= cnt + CNT_ONE;
          end else begin
            state <= STABLE_LO;
            cnt   <= '0;
          end
        end
        STABLE_HI: begin
          if (go_lo) begin
            state <= STABLE_LO;
            level <= 1'b0;
          end else if (!s) begin
            state <= CHECK_LO;
            cnt   <= CNT_ONE;
          end
        end
        CHECK_LO: begin
          if (go_lo) begin
            state <= STABLE_LO;
            cnt   <= '0;
            level <= 1'b0;
          end else if (!s) begin
            cnt <= cnt + CNT_ONE;
          end else begin
            state <= STABLE_HI;
            cnt   <= '0;
          end
        end
        default: begin
          state <= STABLE_LO;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

  assign level_o = level;

`ifdef INPUT_DEBOUNCER_EDGE_EN
  logic rise_q;
  logic fall_q;

  // Pulses load on the same edge as level, so they line up with its first new-value cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= go_hi;
      fall_q <= go_lo;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - directed and randomized checks of input_debouncer against a run-length model
module tb_input_debouncer;

  localparam int S = 2;
  localparam int D = 4;
`ifdef INPUT_DEBOUNCER_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic raw = 1'b0;
  logic level;
  logic rise;
  logic fall;

  int total = 0;
  int bad = 0;

  // Reference: s is raw delayed S edges; level flips once s has differed from it for D straight samples.
  bit sm [S];
  bit m_level;
  int m_run;
  bit m_rise;
  bit m_fall;

  int lat;
  int pulses;
  int k;
  int n;
  bit r;
  bit rs;

  input_debouncer dut (
    .clk_i   (clk),
    .reset_i (reset),
    .raw_i   (raw),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit rin);
    bit s_now;
    if (rst) begin
      for (int i = 0; i < S; i++) sm[i] = 1'b0;
      m_level = 1'b0;
      m_run   = 0;
      m_rise  = 1'b0;
      m_fall  = 1'b0;
    end else begin
      s_now  = sm[S-1];
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s_now != m_level) begin
        m_run++;
        if (m_run >= D) begin
          m_level = s_now;
          m_run   = 0;
          m_rise  = s_now;
          m_fall  = !s_now;
        end
      end else begin
        m_run = 0;
      end
      for (int i = S - 1; i > 0; i--) sm[i] = sm[i-1];
      sm[0] = rin;
    end
  endtask

  task automatic step(input bit rst, input bit rin);
    reset = rst;
    raw   = rin;
    @(posedge clk);
    model_edge(rst, rin);
    #1;
    chk("level", level, m_level);
    chk("rise", rise, EDGE & m_rise);
    chk("fall", fall, EDGE & m_fall);
  endtask

  // Holds rin for maxn edges; reports the first edge index where level_o equals rin, and pulses seen.
  task automatic hold_measure(input bit rin, input int maxn, output int lat_o, output int pulses_o);
    lat_o = 0;
    pulses_o = 0;
    for (int i = 1; i <= maxn; i++) begin
      step(1'b0, rin);
      if (lat_o == 0 && level === rin) lat_o = i;
      pulses_o += int'(rise) + int'(fall);
    end
  endtask

  initial begin
    // Reset, then quiet low input.
    step(1'b1, 1'b0);
    chk("reset_level", level, 0);
    chk("reset_rise", rise, 0);
    chk("reset_fall", fall, 0);
    hold_measure(1'b0, 10, lat, pulses);
    chk("quiet_pulses", pulses, 0);
    chk("quiet_level", level, 0);

    // Clean 0->1 acceptance latency.
    hold_measure(1'b1, 12, lat, pulses);
    chk("rise_latency", lat, S + D);
    chk("rise_pulses", pulses, EDGE ? 1 : 0);

    // Constant high after acceptance: no further pulses.
    hold_measure(1'b1, 20, lat, pulses);
    chk("const_pulses", pulses, 0);

    // Return low, then a 3-cycle bounce that must be rejected.
    hold_measure(1'b0, 12, lat, pulses);
    chk("fall_latency", lat, S + D);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      pulses += int'(rise) + int'(fall);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      pulses += int'(rise) + int'(fall);
    end
    chk("bounce_level", level, 0);
    chk("bounce_pulses", pulses, 0);

    // Toggle from high, then hold low: count from the final 1->0.
    hold_measure(1'b1, 10, lat, pulses);
    chk("pre_toggle_level", level, 1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    hold_measure(1'b0, 12, lat, pulses);
    chk("toggle_fall_latency", lat, S + D);
    chk("toggle_fall_pulses", pulses, EDGE ? 1 : 0);

    // Reset in CHECK_HI with cnt=2, then acceptance from scratch.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    chk("mid_check_cnt", 32'(dut.cnt), 2);
    chk("mid_check_level", level, 0);
    step(1'b1, 1'b1);
    chk("post_reset_cnt", 32'(dut.cnt), 0);
    chk("post_reset_level", level, 0);
    hold_measure(1'b1, 12, lat, pulses);
    chk("reset_release_latency", lat, S + D);
    chk("reset_release_pulses", pulses, EDGE ? 1 : 0);

    // Random runs with occasional reset, checked each cycle by the model.
    k = 0;
    while (k < 600) begin
      r = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 7);
      for (int j = 0; j < n; j++) begin
        rs = ($urandom_range(0, 63) == 0);
        step(rs, r);
        k++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops on raw_i (legal >= 2).
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronised samples needed to accept a new level (legal >= 1).
REQ-003 clk_i  input  1  single clock; all flops rising-edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 raw_i  input  1  asynchronous, bouncy switch/sensor input.
REQ-006 level_o  output  1  debounced level; drives state_machine in_i directly.
REQ-007 rise_o  output  1  one-cycle pulse on accepted 0->1 change.
REQ-008 fall_o  output  1  one-cycle pulse on accepted 1->0 change.

Function
REQ-009 raw_i SHALL pass through a SYNC_STAGES-deep flop chain; its last stage "s" SHALL be the only signal the FSM samples.
REQ-010 FSM states SHALL be STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO.
REQ-011 STABLE_LO with s=1 -> CHECK_HI, cnt=1. STABLE_HI with s=0 -> CHECK_LO, cnt=1. Otherwise hold.
REQ-012 CHECK_x with s equal to candidate and cnt<DEBOUNCE_CYCLES-1 -> cnt+1, stay.
REQ-013 CHECK_x with s equal to candidate and cnt=DEBOUNCE_CYCLES-1 -> STABLE_x, cnt=0, level_o flips on the same edge.
REQ-014 CHECK_x with s reverting -> previous STABLE state, cnt=0, level_o unchanged, no pulse.
REQ-015 DEBOUNCE_CYCLES=1: STABLE state with s differing SHALL flip level_o directly; CHECK states unused.
REQ-016 Latency: counting the first edge that samples a new raw_i value as edge 1, level_o SHALL change at edge SYNC_STAGES+DEBOUNCE_CYCLES if raw_i holds (S=2, D=4: edge 6).
REQ-017 rise_o/fall_o SHALL be registered, high exactly one cycle, in the first cycle level_o shows its new value.
REQ-018 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); cnt SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap).
REQ-019 A constant raw_i SHALL never produce a pulse after its initial acceptance.

Reset
REQ-020 reset_i SHALL override all other conditions, including mid-CHECK.
REQ-021 On reset: all sync flops 0, state STABLE_LO, cnt 0, level_o 0, rise_o 0, fall_o 0.
REQ-022 raw_i high across reset release SHALL yield normal acceptance latency (REQ-016) and one rise_o pulse.

Configuration
REQ-023 Macro INPUT_DEBOUNCER_EDGE_EN defined: rise_o/fall_o behave per REQ-017.
REQ-024 Macro undefined: rise_o/fall_o ports remain, tied to 0, no pulse flops synthesised; level_o unaffected.

Structure
REQ-025 Package input_debouncer_pkg SHALL hold the state enum typedef and default constants SYNC_STAGES_DEF=2, DEBOUNCE_CYCLES_DEF=4.
REQ-026 Synchroniser SHALL be sub-module sync_chain (parameter STAGES, ports clk_i, reset_i, d_i, q_o), reset to 0.

Verification (S=2, D=4, EDGE_EN defined unless noted)
REQ-027 Reset 1 cycle, raw_i=0 held 10 cycles -> level_o=0, rise_o/fall_o never 1.
REQ-028 raw_i 0->1 held -> level_o=1 at edge 6, rise_o=1 for exactly that one cycle.
REQ-029 raw_i pulses 1 for 3 cycles then 0 (bounce) -> FSM enters CHECK_HI, returns STABLE_LO, level_o stays 0, no pulse.
REQ-030 level_o=1, raw_i toggles 1/0/1/0 each cycle then 0 held -> level_o=0 exactly 6 edges after final 1->0, one fall_o pulse.
REQ-031 raw_i=1, reset_i asserted in CHECK_HI with cnt=2 -> next cycle level_o=0, cnt=0; after release with raw_i=1, level_o=1 at edge 6.
REQ-032 Macro undefined, repeat REQ-028 -> level_o timing identical, rise_o constantly 0.
